// File: rtl/mfrc522_pkg.sv
// Shared definitions for the MFRC522-style SPI register link:
// responder FSM states and address-byte field positions.
package mfrc522_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

    localparam int RW_BIT  = 7;
    localparam int ADDR_HI = 6;
    localparam int ADDR_LO = 1;
    localparam int ERR_BIT = 0;
    localparam int ADDR_W  = 6;

    // Build an address byte as the master sends it (rw=1 is a read).
    function automatic logic [7:0] addr_byte(input logic rw,
                                             input logic [ADDR_W-1:0] addr);
        return {rw, addr, 1'b0};
    endfunction

endpackage

// File: rtl/mfrc522_spi_responder_if.sv
// SPI bus bundle between an SPI master and the register responder.
// The master drives select, clock and MOSI; the responder drives MISO.
interface mfrc522_spi_responder_if;

    logic spi_cs_n;
    logic spi_sclk;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_cs_n,
        output spi_sclk,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_cs_n,
        input  spi_sclk,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with
// single-cycle rise/fall strobes taken from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sh;
    logic              prev;

    assign q    = sh[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

    // Shift the pin through the chain and remember the last synced level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sh   <= STAGES'({sh, d});
            prev <= sh[STAGES-1];
        end
    end

endmodule

// File: rtl/mfrc522_spi_responder.sv
// SPI Mode 0 register responder: address byte {rw, addr, b0}, then
// read or write data bytes at that address for the rest of the frame.
module mfrc522_spi_responder
    import mfrc522_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mfrc522_spi_responder_if.slave spi,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic                  reg_rd_en,
    input  logic [7:0]            reg_rdata,
    output logic                  reg_wr_en,
    output logic [7:0]            reg_wdata,
    output logic                  frame_active,
    output logic                  err_abort,
    output logic                  err_addr
);

    logic cs_q, cs_rise, cs_fall;
    logic sclk_q, sclk_rise, sclk_fall;
    logic mosi_q, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi.spi_cs_n),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi.spi_sclk),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (spi.spi_mosi),
        .q    (mosi_q),
        .rise (mosi_rise),
        .fall (mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{cs_q, sclk_q, mosi_rise, mosi_fall};

    state_t     state;
    logic [2:0] cnt;
    logic [6:0] rx;
    logic [7:0] tx;
    logic       rd_mode;
    logic       first_data;
    logic       ld_tx;
    logic       miso;

    logic [7:0] rx_byte;
    logic       byte_done;

    assign rx_byte   = {rx, mosi_q};
    assign byte_done = sclk_rise && (state != ST_IDLE) && (cnt == 3'd7);

    assign spi.spi_miso    = miso;
    assign spi.spi_miso_oe = frame_active;

    // Frame FSM: bit counting, byte decode, register strobes and MISO.
    // The tx register rotates, so a read byte repeats until refetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 3'd0;
            rx           <= 7'd0;
            tx           <= 8'd0;
            rd_mode      <= 1'b0;
            first_data   <= 1'b0;
            ld_tx        <= 1'b0;
            miso         <= 1'b0;
            reg_addr     <= '0;
            reg_rd_en    <= 1'b0;
            reg_wr_en    <= 1'b0;
            reg_wdata    <= 8'd0;
            frame_active <= 1'b0;
            err_abort    <= 1'b0;
            err_addr     <= 1'b0;
        end else begin
            reg_rd_en <= 1'b0;
            reg_wr_en <= 1'b0;
            err_abort <= 1'b0;
            err_addr  <= 1'b0;
            ld_tx     <= reg_rd_en;
            if (cs_rise) begin
                err_abort    <= (state != ST_IDLE) && (cnt != 3'd0);
                state        <= ST_IDLE;
                frame_active <= 1'b0;
                miso         <= 1'b0;
                cnt          <= 3'd0;
                rx           <= 7'd0;
                tx           <= 8'd0;
            end else if (cs_fall) begin
                state        <= ST_ADDR;
                frame_active <= 1'b1;
                miso         <= 1'b0;
                cnt          <= 3'd0;
                rx           <= 7'd0;
                tx           <= 8'd0;
                rd_mode      <= 1'b0;
                first_data   <= 1'b0;
            end else begin
                if (sclk_rise && state != ST_IDLE) begin
                    cnt <= cnt + 3'd1;
                    rx  <= rx_byte[6:0];
                end
                if (sclk_fall) begin
                    if (state == ST_DATA) begin
                        miso <= tx[7];
                        tx   <= {tx[6:0], tx[7]};
                    end else begin
                        miso <= 1'b0;
                    end
                end else if (ld_tx && state == ST_DATA) begin
                    tx <= reg_rdata;
                end
                if (byte_done) begin
                    unique case (state)
                        ST_ADDR: begin
                            reg_addr   <= rx_byte[ADDR_HI:ADDR_LO];
                            rd_mode    <= rx_byte[RW_BIT];
                            first_data <= 1'b1;
                            if (rx_byte[ERR_BIT]) begin
                                err_addr <= 1'b1;
                                state    <= ST_IGNORE;
                            end else begin
                                reg_rd_en <= rx_byte[RW_BIT];
                                state     <= ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            first_data <= 1'b0;
                            if (rd_mode) begin
                                reg_rd_en <= !first_data;
                            end else begin
                                reg_wr_en <= 1'b1;
                                reg_wdata <= rx_byte;
                            end
                        end
                        ST_IDLE, ST_IGNORE: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mfrc522_spi_responder.sv
// Directed bench for the SPI register responder: table of frames with
// hand-computed register strobes and MISO bytes, plus reset sequences.
module tb_mfrc522_spi_responder;
    import mfrc522_pkg::*;

    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mfrc522_spi_responder_if spi();

    logic [5:0] reg_addr;
    logic       reg_rd_en;
    logic [7:0] reg_rdata;
    logic       reg_wr_en;
    logic [7:0] reg_wdata;
    logic       frame_active;
    logic       err_abort;
    logic       err_addr;

    mfrc522_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi         (spi),
        .reg_addr    (reg_addr),
        .reg_rd_en   (reg_rd_en),
        .reg_rdata   (reg_rdata),
        .reg_wr_en   (reg_wr_en),
        .reg_wdata   (reg_wdata),
        .frame_active(frame_active),
        .err_abort   (err_abort),
        .err_addr    (err_addr)
    );

    int checks = 0;
    int errors = 0;

    int         rd_cnt = 0;
    int         abort_cnt = 0;
    int         eaddr_cnt = 0;
    int         miso_viol = 0;
    int         oe_viol = 0;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] wd_q[$];
    logic [5:0] wa_q[$];

    function automatic logic [7:0] reg_model(input logic [5:0] a);
        return (a == 6'h37) ? 8'h92 : {a, 2'b01};
    endfunction

    // Register file answers exactly one clock after the read strobe.
    always @(posedge clk)
        reg_rdata <= reg_rd_en ? reg_model(reg_addr) : 8'h00;

    // Log strobes and watch MISO/OE against the frame window.
    always @(negedge clk) begin
        if (reg_wr_en) begin
            wd_q.push_back(reg_wdata);
            wa_q.push_back(reg_addr);
        end
        if (reg_rd_en) begin
            rd_cnt++;
            rd_addr = reg_addr;
        end
        if (err_abort) abort_cnt++;
        if (err_addr) eaddr_cnt++;
        if (!frame_active && spi.spi_miso) miso_viol++;
        if (spi.spi_miso_oe != frame_active) oe_viol++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi.spi_mosi = tx[i];
            repeat (HALF) @(negedge clk);
            rx[i] = spi.spi_miso;
            spi.spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.spi_sclk = 1'b0;
        end
    endtask

    typedef struct {
        int          nbytes;
        int          tail;
        logic [31:0] mosi;
        int          exp_wr;
        logic [23:0] exp_wd;
        logic [5:0]  exp_addr;
        int          exp_rd;
        int          exp_abort;
        int          exp_eaddr;
        logic [31:0] exp_miso;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int          wr0 = wd_q.size();
        int          rd0 = rd_cnt;
        int          ab0 = abort_cnt;
        int          ea0 = eaddr_cnt;
        int          nwr;
        logic [7:0]  r;
        logic [31:0] got;
        got = 32'h0;
        spi.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        chk($sformatf("v%0d_active", idx), int'(frame_active), 1);
        for (int b = 0; b < v.nbytes; b++) begin
            spi_byte(v.mosi[31-8*b -: 8], 8, r);
            got[31-8*b -: 8] = r;
        end
        if (v.tail > 0)
            spi_byte(v.mosi[31-8*v.nbytes -: 8], v.tail, r);
        repeat (HALF) @(negedge clk);
        spi.spi_cs_n = 1'b1;
        repeat (3*HALF) @(negedge clk);
        chk($sformatf("v%0d_idle", idx), int'(frame_active), 0);
        nwr = wd_q.size() - wr0;
        chk($sformatf("v%0d_wr_cnt", idx), nwr, v.exp_wr);
        for (int k = 0; k < nwr && k < v.exp_wr; k++) begin
            chk($sformatf("v%0d_wdata%0d", idx, k),
                int'(wd_q[wr0+k]), int'(v.exp_wd[23-8*k -: 8]));
            chk($sformatf("v%0d_waddr%0d", idx, k),
                int'(wa_q[wr0+k]), int'(v.exp_addr));
        end
        chk($sformatf("v%0d_rd_cnt", idx), rd_cnt - rd0, v.exp_rd);
        if (v.exp_rd > 0)
            chk($sformatf("v%0d_rd_addr", idx), int'(rd_addr), int'(v.exp_addr));
        chk($sformatf("v%0d_abort", idx), abort_cnt - ab0, v.exp_abort);
        chk($sformatf("v%0d_err_addr", idx), eaddr_cnt - ea0, v.exp_eaddr);
        chk($sformatf("v%0d_reg_addr", idx), int'(reg_addr), int'(v.exp_addr));
        for (int b = 0; b < v.nbytes; b++)
            chk($sformatf("v%0d_miso%0d", idx, b),
                int'(got[31-8*b -: 8]), int'(v.exp_miso[31-8*b -: 8]));
    endtask

    function automatic int all_outs();
        return int'({spi.spi_miso, spi.spi_miso_oe, reg_addr, reg_rd_en,
                     reg_wr_en, reg_wdata, frame_active, err_abort, err_addr});
    endfunction

    initial begin
        logic [7:0] r;
        int         ab0;
        int         wr0;
        vec_t       rv;

        vecs[0] = '{2, 0, 32'h020C0000, 1, 24'h0C0000, 6'h01, 0, 0, 0, 32'h0};
        vecs[1] = '{2, 0, 32'hEE000000, 0, 24'h0, 6'h37, 1, 0, 0, 32'h00920000};
        vecs[2] = '{4, 0, 32'h12A1B2C3, 3, 24'hA1B2C3, 6'h09, 0, 0, 0, 32'h0};
        vecs[3] = '{1, 5, 32'h020C0000, 0, 24'h0, 6'h01, 0, 1, 0, 32'h0};
        vecs[4] = '{2, 0, 32'h03550000, 0, 24'h0, 6'h01, 0, 0, 1, 32'h0};
        vecs[5] = '{3, 0, 32'h8A000000, 0, 24'h0, 6'h05, 2, 0, 0, 32'h00151500};

        rst_n = 1'b0;
        spi.spi_cs_n = 1'b1;
        spi.spi_sclk = 1'b0;
        spi.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_outputs", all_outs(), 0);

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], i);

        ab0 = abort_cnt;
        wr0 = wd_q.size();
        spi.spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'hEE, 8, r);
        spi_byte(8'h00, 3, r);
        chk("mid_addr_latched", int'(reg_addr), 'h37);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", all_outs(), 0);
        spi.spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3*HALF) @(negedge clk);
        chk("mid_reset_no_abort", abort_cnt - ab0, 0);
        chk("mid_reset_no_write", wd_q.size() - wr0, 0);
        chk("mid_reset_idle", all_outs(), 0);

        rv = vecs[0];
        rv.mosi = {addr_byte(1'b0, 6'h2A), 8'h5C, 16'h0};
        rv.exp_wd = 24'h5C0000;
        rv.exp_addr = 6'h2A;
        run_vec(rv, 10);

        chk("miso_outside_frame", miso_viol, 0);
        chk("oe_vs_frame_active", oe_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfrc522_spi_responder.md
MFRC522_SPI_RESPONDER -- requirements
Module: mfrc522_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth applied to spi_cs_n, spi_sclk and spi_mosi.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 spi_cs_n  input  1  chip select from the SPI master, active-low.
REQ-005 spi_sclk  input  1  SPI clock, Mode 0 (CPOL=0, CPHA=0).
REQ-006 spi_mosi  input  1  master-to-responder data, MSB first.
REQ-007 spi_miso  output  1  responder-to-master data, MSB first.
REQ-008 spi_miso_oe  output  1  high while the synchronized CS is asserted.
REQ-009 reg_addr  output  6  register address of the current frame.
REQ-010 reg_rd_en  output  1  one-clk pulse requesting reg_rdata for reg_addr.
REQ-011 reg_rdata  input  8  register data, sampled exactly 1 clk after reg_rd_en.
REQ-012 reg_wr_en  output  1  one-clk pulse committing reg_wdata to reg_addr.
REQ-013 reg_wdata  output  8  write data, valid while reg_wr_en is high.
REQ-014 frame_active  output  1  high from the synchronized CS fall to the synchronized CS rise.
REQ-015 err_abort  output  1  one-clk pulse when CS rises with a partial byte received (bit count not 0).
REQ-016 err_addr  output  1  one-clk pulse when the address byte has bit0 = 1; that frame is ignored.

Function
REQ-017 Inputs SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized sclk; the minimum supported sclk half-period SHALL be SYNC_STAGES+2 clk.
REQ-018 States: IDLE, ADDR, DATA, IGNORE; the block SHALL enter ADDR on the synchronized CS fall and return to IDLE on the synchronized CS rise from any state.
REQ-019 MOSI SHALL be sampled into an rx shift register on each synchronized sclk rise; a 3-bit counter SHALL count bits and wrap 7->0.
REQ-020 Address byte {rw, addr[5:0], b0}: rw=1 means read and rw=0 means write. On completion: latch reg_addr; if b0=1, pulse err_addr and go to IGNORE; else go to DATA; if read, also pulse reg_rd_en in the same cycle.
REQ-021 Read: reg_rdata SHALL be loaded into the tx shift register 1 clk after reg_rd_en, before the next synchronized sclk fall; each later data byte SHALL re-issue reg_rd_en at the same address at that byte's 8th rise. MOSI bytes SHALL be ignored.
REQ-022 Write: each completed data byte SHALL pulse reg_wr_en with reg_wdata = that byte at the same reg_addr, 1 clk after the 8th rise; unlimited bytes are allowed (FIFO-style burst).
REQ-023 MISO SHALL change only on synchronized sclk falls; during the address byte and in IGNORE, MISO SHALL be 0; the first MISO bit of a data byte SHALL be valid before that byte's first rise.
REQ-024 spi_miso SHALL be 0 whenever CS is deasserted.
REQ-025 CS rising mid-byte: discard the partial byte, no reg_wr_en, pulse err_abort; CS rising after the address byte only: no register access.
REQ-026 A CS fall in the same clk as a pending reg_wr_en SHALL still issue that write.

Reset
REQ-027 On rst_n low: state IDLE, counter 0, shift registers 0, all outputs 0 (reg_addr=0, reg_wdata=0, spi_miso=0, spi_miso_oe=0, pulses 0), synchronizer flops at the CS-inactive level (cs 1, sclk 0, mosi 0).
REQ-028 Reset mid-frame SHALL abandon the frame without any pulse; the next frame SHALL start only after a fresh synchronized CS fall.

Structure
REQ-029 The state encoding and address-byte field positions (RW bit 7, address bits 6:1) SHALL live in a shared mfrc522_pkg, reused by the master-side interface.
REQ-030 A sub-module spi_sync_edge SHALL hold the synchronizer and rise/fall detection, one instance per input.

Verification
REQ-031 Write frame 0x02,0x0C -> exactly one reg_wr_en with reg_addr=0x01, reg_wdata=0x0C.
REQ-032 Read frame 0xEE,0x00 with reg_rdata=0x92 -> one reg_rd_en, reg_addr=0x37, second MISO byte 0x92, first MISO byte 0x00.
REQ-033 Burst write 0x12,0xA1,0xB2,0xC3 -> three reg_wr_en pulses at addr 0x09 with data 0xA1, 0xB2, 0xC3 in order.
REQ-034 Write 0x02 then CS raised after 5 data bits -> err_abort pulse, no reg_wr_en.
REQ-035 Address byte 0x03 -> err_addr pulse, MISO 0, no register access; rst_n asserted mid-read -> all outputs 0 and the next frame decodes correctly.
